// File: rtl/serial_rx_8bit_pkg.sv
// Shared definitions for the serial receiver: frame width, default bit timing
// and the receiver FSM state encoding.
package serial_rx_8bit_pkg;

  localparam int DATA_WIDTH         = 8;
  localparam int DEFAULT_BIT_CYCLES = 4;
  localparam int BIT_IDX_W          = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Width of the bit-period down-counter; it must hold BIT_CYCLES-1.
  function automatic int timer_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/serial_rx_8bit_if.sv
// Serial line in, byte plus load strobe out; the receiver is the master side,
// the line driver / downstream register is the slave side.
interface serial_rx_8bit_if;
  import serial_rx_8bit_pkg::*;

  logic                  enable;
  logic                  rx_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  load;
  logic                  frame_err;
  logic                  busy;

  modport master (
    input  enable,
    input  rx_in,
    output data_out,
    output load,
    output frame_err,
    output busy
  );

  modport slave (
    output enable,
    output rx_in,
    input  data_out,
    input  load,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/serial_rx_8bit_bit_timer.sv
// Bit-period down-counter: flags the mid-point of the start bit (half_tc)
// and each subsequent bit boundary (full_tc), reloading itself on full_tc.
module serial_rx_8bit_bit_timer
  import serial_rx_8bit_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  output logic half_tc,
  output logic full_tc
);

  localparam int            CW     = timer_width(BIT_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF   = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] count_q;

  // Loaded with BIT_CYCLES-1 on clear, so half_tc lands BIT_CYCLES/2 edges
  // after the clear and full_tc every BIT_CYCLES edges after that.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      count_q <= RELOAD;
    end else if (clear || (count_q == '0)) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_q - ONE;
    end
  end

  assign half_tc = (count_q == HALF);
  assign full_tc = (count_q == '0);

endmodule

// File: rtl/serial_rx_8bit.sv
// Serial-to-parallel receiver: start bit, 8 data bits LSB first, stop bit.
// Drives a byte and a one-cycle load strobe straight into an 8-bit register.
module serial_rx_8bit
  import serial_rx_8bit_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic            Clk,
  input  logic            reset,
  serial_rx_8bit_if.master bus
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_WIDTH - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);

  rx_state_e             state_q, state_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  load_q, load_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q;
  logic                  timer_clear;
  logic                  half_tc;
  logic                  full_tc;

  serial_rx_8bit_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .Clk     (Clk),
    .reset   (reset),
    .clear   (timer_clear),
    .half_tc (half_tc),
    .full_tc (full_tc)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  // The timer is held cleared in IDLE and re-cleared at the start-bit
  // mid-point, so every later full_tc falls in the middle of a bit.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    load_d      = 1'b0;
    frame_err_d = frame_err_q;
    timer_clear = 1'b0;

    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        if (!bus.rx_in) begin
          state_d = START;
        end
      end

      START: begin
        if (half_tc) begin
          timer_clear = 1'b1;
          if (!bus.rx_in) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (full_tc) begin
          shift_d   = {bus.rx_in, shift_q[DATA_WIDTH-1:1]};
          bit_idx_d = bit_idx_q + IDX_ONE;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (full_tc) begin
          if (bus.rx_in) begin
            data_d      = shift_q;
            load_d      = 1'b1;
            frame_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Dropping enable abandons any partial frame without touching results.
    if (!bus.enable) begin
      state_d     = IDLE;
      load_d      = 1'b0;
      data_d      = data_q;
      frame_err_d = frame_err_q;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.load      = load_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_rx_8bit.sv
// Directed and randomized frames against a frame-level reference model of the
// receiver; load timing and results are derived from the frame layout.
module tb_serial_rx_8bit;

  localparam int BC           = 4;
  localparam int FRAME_CYCLES = 10 * BC;
  localparam int STOP_SAMPLE  = BC / 2 + 9 * BC;

  logic Clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_data;
  logic       exp_ferr;
  logic [7:0] reg_q;

  serial_rx_8bit_if rx_bus ();

  serial_rx_8bit #(
    .BIT_CYCLES (BC)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (rx_bus.master)
  );

  always #5 Clk = ~Clk;

  // Stand-in for the downstream 8-bit load register.
  always @(posedge Clk or negedge reset) begin
    if (!reset) reg_q <= 8'h00;
    else if (rx_bus.load) reg_q <= rx_bus.data_out;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input logic val);
    rx_bus.rx_in = val;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input logic exp_load, input logic exp_busy);
    check_bit("load", rx_bus.load, exp_load);
    check_bit("busy", rx_bus.busy, exp_busy);
    check_byte("data_out", rx_bus.data_out, exp_data);
    check_bit("frame_err", rx_bus.frame_err, exp_ferr);
  endtask

  // One frame, first edge (T) samples the start bit; abort_at stops early.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_at);
    for (int j = 0; j < FRAME_CYCLES; j++) begin
      int   bit_no;
      logic val;
      bit_no = j / BC;
      if (bit_no == 0) val = 1'b0;
      else if (bit_no <= 8) val = b[bit_no-1];
      else val = stop_bit;
      step(val);
      if (j == STOP_SAMPLE) begin
        if (stop_bit) begin
          exp_data = b;
          exp_ferr = 1'b0;
        end else begin
          exp_ferr = 1'b1;
        end
      end
      check_all((j == STOP_SAMPLE) && stop_bit,
                (j < STOP_SAMPLE) || ((j == FRAME_CYCLES - 1) && !stop_bit));
      if (j == abort_at) break;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      check_all(1'b0, 1'b0);
    end
  endtask

  // A low stop bit leaves the line low, so the receiver starts a frame that
  // the returning high line turns into a start glitch.
  task automatic recover_after_bad_stop();
    step(1'b1);
    check_all(1'b0, 1'b1);
    step(1'b1);
    check_all(1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    reset         = 1'b0;
    rx_bus.enable = 1'b1;
    rx_bus.rx_in  = 1'b1;
    exp_data      = 8'h00;
    exp_ferr      = 1'b0;

    #2;
    check_all(1'b0, 1'b0);
    @(posedge Clk);
    #1;
    reset = 1'b1;
    idle_cycles(3);

    $display("[TB] good frame D3");
    send_frame(8'hD3, 1'b1, -1);
    check_byte("reg_8bit", reg_q, 8'hD3);
    idle_cycles(2);

    $display("[TB] bad stop AA");
    send_frame(8'hAA, 1'b0, -1);
    recover_after_bad_stop();
    idle_cycles(2);

    $display("[TB] start glitch");
    step(1'b0);
    check_all(1'b0, 1'b1);
    step(1'b1);
    check_all(1'b0, 1'b1);
    step(1'b1);
    check_all(1'b0, 1'b0);
    idle_cycles(2);

    $display("[TB] back-to-back 55 AA");
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hAA, 1'b1, -1);
    idle_cycles(2);

    $display("[TB] reset during data bit 4");
    send_frame(8'hC6, 1'b1, 5 * BC + 1);
    reset        = 1'b0;
    rx_bus.rx_in = 1'b1;
    exp_data     = 8'h00;
    exp_ferr     = 1'b0;
    #1;
    check_all(1'b0, 1'b0);
    @(posedge Clk);
    #1;
    reset = 1'b1;
    idle_cycles(3);
    send_frame(8'h0F, 1'b1, -1);
    idle_cycles(2);

    $display("[TB] enable drop during data bit 2");
    send_frame(8'h3C, 1'b1, 3 * BC + 1);
    rx_bus.enable = 1'b0;
    step(1'b1);
    check_all(1'b0, 1'b0);
    step(1'b0);
    check_all(1'b0, 1'b0);
    rx_bus.enable = 1'b1;
    idle_cycles(3);

    $display("[TB] randomized frames");
    for (int n = 0; n < 8; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, -1);
      if (!rs) recover_after_bad_stop();
      idle_cycles($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_8bit.md
Name: serial_rx_8bit

Overview:
- Serial-to-parallel receiver feeding the team's 8-bit load register (Reg_8bit) directly upstream.
- Receives one asynchronous-style frame on a single line: start bit, 8 data bits LSB first, stop bit.
- Presents the received byte on data_out with a one-cycle load strobe, wired straight to the register's data_in/load.
- Flags malformed frames.

Parameters:
- DATA_WIDTH, 8, data bits per frame (fixed at 8 for this release; register width).
- BIT_CYCLES, 4, Clk cycles per bit period; even, >= 2.

Ports:
- Clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted.
- enable  input  1  receiver enable; 0 forces IDLE.
- rx_in  input  1  serial line, idle high, synchronous to Clk (no synchronizer in this block).
- data_out  output  8  last good received byte; connects to Reg_8bit data_in.
- load  output  1  one-cycle pulse when data_out updates; connects to Reg_8bit load.
- frame_err  output  1  stop bit sampled low on last frame.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - FSM goes to IDLE; counters are cleared.
  - data_out=8'h00, load=0, frame_err=0, busy=0.
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If enable=1 and rx_in=0 at edge T, go to START; cycle counter=0. Call this edge T.
  - busy=1 from after edge T.
- START:
  - Count cycles; sample rx_in at edge T+BIT_CYCLES/2 (mid-bit).
  - If rx_in=0, go to DATA with bit_idx=0 and counter=0.
  - If rx_in=1, treat as a glitch: go to IDLE with no error and no load.
- DATA:
  - Bit k (k=0..7) is sampled at edge T+BIT_CYCLES/2+(k+1)*BIT_CYCLES and shifted in LSB first (bit 0 received first becomes data_out[0]).
  - After bit 7, go to STOP.
- STOP:
  - Sample at edge T+BIT_CYCLES/2+9*BIT_CYCLES.
  - If rx_in=1: data_out<=shift register, load=1 for exactly one cycle, frame_err<=0.
  - If rx_in=0: frame_err<=1, no load, data_out unchanged.
  - Either way, go to IDLE on the same edge.
- Latency: with BIT_CYCLES=4, load is high during the cycle after edge T+38. Nominal frame period is 40 cycles.
- frame_err holds its value until the next completed frame (cleared on a good stop, set on a bad stop). A start glitch does not touch it.
- enable=0 in any state: go to IDLE on the next edge. No load, frame_err unchanged, the partial byte is discarded.
- Line held low after a bad stop bit: IDLE sees rx_in=0 on the next edge and starts a new frame. This is required behaviour.
- Back-to-back frames: a start edge in the cycle immediately after the STOP→IDLE transition must be accepted. No dead cycle is required beyond that one.
- load never asserts in two consecutive cycles.
- data_out is stable except on the load edge.
- reset asserted mid-frame: immediate return to the reset values above; the partial byte is lost.

Decomposition:
- Shared header/package rx_defs:
  - FSM state encodings as localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - DATA_WIDTH.
  - Default BIT_CYCLES.
- Sub-module bit_timer:
  - Parameterised down-counter with half-period and full-period terminal-count outputs.
  - Synchronous clear; same Clk and async active-low reset.
- Top level: FSM, bit index counter, shift register, output registers.
- Top level instantiated alongside Reg_8bit in the system wrapper.

Test Plan:
- Good frame: BIT_CYCLES=4, drive frame for 8'hD3 (start 0, bits 1,1,0,0,1,0,1,1, stop 1) with start at edge T.
  - Required: load=1 only in the cycle after T+38, data_out=8'hD3, frame_err=0.
  - Required: Reg_8bit output=8'hD3 one cycle later.
- Bad stop bit: send 8'hAA with stop bit=0 after a good 8'hD3.
  - Required: frame_err=1 after T+38, no load pulse, data_out stays 8'hD3.
- Start glitch: rx_in low for 1 cycle only.
  - Required: busy high for 2 cycles, FSM back to IDLE, no load, frame_err unchanged.
- Back-to-back: 8'h55 immediately followed by 8'hAA (second start edge at T+40).
  - Required: load pulses after T+38 and after T+78; data_out 8'h55 then 8'hAA.
- Reset mid-frame: assert reset=0 during data bit 4.
  - Required: data_out=8'h00, busy=0, load=0 immediately, without waiting for Clk.
  - Required: the next full frame 8'h0F is received correctly.
- Enable drop: enable=0 during data bit 2 of a frame.
  - Required: busy=0 on the next edge, no load, data_out unchanged.
